// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame size and idle line level.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; both flops reset to RESET_VAL.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling, valid/ack byte handoff.
// state     | meaning
// IDLE      | line high, waiting for a falling edge
// START     | counting to mid start bit to reject glitches
// DATA      | sampling 8 data bits at bit centres, LSB first
// STOP      | sampling the stop bit
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ack,
  output logic                      frame_error,
  output logic                      overrun,
  output logic                      busy
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam int              H        = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_MID  = CW'(H - 1);
  localparam logic [2:0]      BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t            state, state_next;
  logic [CW-1:0]             clk_cnt, clk_cnt_next;
  logic [2:0]                bit_cnt, bit_cnt_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic                      rx_s;
  logic                      load_byte;
  logic                      stop_bad;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(UART_IDLE_LEVEL)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (rx),
    .q      (rx_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    load_byte    = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_s != UART_IDLE_LEVEL) begin
          state_next   = START;
          clk_cnt_next = '0;
        end
      end
      START: begin
        if (clk_cnt == CNT_MID) begin
          if (rx_s != UART_IDLE_LEVEL) begin
            state_next   = DATA;
            clk_cnt_next = '0;
            bit_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          shift_next   = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
          clk_cnt_next = '0;
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_next = STOP;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          if (rx_s == UART_IDLE_LEVEL) begin
            load_byte  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A held-low break stays here so it reports only one framing error
        if (rx_s == UART_IDLE_LEVEL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A new byte landing in the same cycle as ack keeps valid high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data        <= '0;
      valid       <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= stop_bad;
      if (load_byte) begin
        data    <= shift_reg;
        valid   <= 1'b1;
        overrun <= valid & ~ack;
      end else begin
        overrun <= 1'b0;
        if (valid && ack) valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes queued when a frame is sent, checked on completion.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx      = 1'b1;
  logic       ack     = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int fe_cnt, ov_cnt, busy_seen, idx, rise_idx;
  logic valid_q = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ack        (ack),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    fe_cnt    = 0;
    ov_cnt    = 0;
    busy_seen = 0;
  endtask

  // Sample at the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clock);
    if (frame_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (busy === 1'b1) busy_seen++;
    if (valid === 1'b1 && valid_q === 1'b0) rise_idx = idx;
    valid_q = valid;
    idx++;
  endtask

  task automatic idle(input int n, input logic lvl);
    for (int i = 0; i < n; i++) begin
      tick();
      rx = lvl;
    end
  endtask

  task automatic ack_pulse();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // rx falls just after tick 0; the posedge sampling it counts as edge 1,
  // so a rise seen at tick k means valid rose on edge k.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ack_at);
    logic [9:0] bits;
    bits     = {stop_bit, b, 1'b0};
    idx      = 0;
    rise_idx = -1;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        rx  = bits[i];
        ack = ((i * CPB + c) == ack_at);
      end
    end
  endtask

  task automatic check_pop(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=0x%0h expected=<scoreboard empty>", tag, data);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(data), 32'(e));
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    idle(5, 1'b1);

    // 1: single good byte, latency H + 9*CPB + 3 = 155
    clear_mon();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    idle(4, 1'b1);
    check("t1_latency", 32'(rise_idx), 32'd155);
    check_pop("t1_data");
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_frame_error_cnt", 32'(fe_cnt), 32'd0);
    check("t1_overrun_cnt", 32'(ov_cnt), 32'd0);
    ack_pulse();
    tick();
    check("t1_valid_after_ack", 32'(valid), 32'd0);

    // 2: 4-cycle glitch rejected at mid start bit
    clear_mon();
    idle(4, 1'b0);
    idle(30, 1'b1);
    check("t2_busy_pulsed", 32'(busy_seen != 0), 32'd1);
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_valid", 32'(valid), 32'd0);
    check("t2_data", 32'(data), 32'hA5);
    check("t2_frame_error_cnt", 32'(fe_cnt), 32'd0);

    // 3: bad stop bit followed by a long break
    clear_mon();
    send_frame(8'h3C, 1'b0, -1);
    idle(40 * CPB, 1'b0);
    check("t3_busy_in_break", 32'(busy), 32'd1);
    idle(6, 1'b1);
    check("t3_busy_after_break", 32'(busy), 32'd0);
    check("t3_frame_error_cnt", 32'(fe_cnt), 32'd1);
    check("t3_data", 32'(data), 32'hA5);
    check("t3_valid", 32'(valid), 32'd0);

    // 4: back-to-back bytes without ack
    clear_mon();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    check_pop("t4_data1");
    check("t4_overrun_after_first", 32'(ov_cnt), 32'd0);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, -1);
    idle(4, 1'b1);
    check_pop("t4_data2");
    check("t4_overrun_cnt", 32'(ov_cnt), 32'd1);
    check("t4_valid", 32'(valid), 32'd1);

    // 5: ack coinciding with completion of the next byte
    ack_pulse();
    idle(2, 1'b1);
    check("t5_valid_cleared", 32'(valid), 32'd0);
    clear_mon();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, -1);
    check_pop("t5_data1");
    check("t5_valid1", 32'(valid), 32'd1);
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1, 154);
    idle(2, 1'b1);
    check_pop("t5_data2");
    check("t5_valid2", 32'(valid), 32'd1);
    check("t5_overrun_cnt", 32'(ov_cnt), 32'd0);
    ack_pulse();
    tick();
    check("t5_valid_after_ack", 32'(valid), 32'd0);

    // 6: reset in the middle of data bit 4 of 0xF0
    clear_mon();
    idle(CPB, 1'b0);
    idle(4 * CPB, 1'b0);
    idle(CPB / 2, 1'b1);
    check("t6_busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_data", 32'(data), 32'h00);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_frame_error", 32'(frame_error), 32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    rx = 1'b1;
    idle(3, 1'b1);
    reset_n = 1'b1;
    idle(5, 1'b1);
    clear_mon();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    idle(4, 1'b1);
    check("t6_latency", 32'(rise_idx), 32'd155);
    check_pop("t6_data");
    check("t6_valid", 32'(valid), 32'd1);
    check("t6_frame_error_cnt", 32'(fe_cnt), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver; the receive-side counterpart of the team's UART transmitter.
- Synchronises the asynchronous serial line and validates the start bit at mid-bit.
- Samples 8 data bits LSB-first at bit centres and checks the stop bit.
- Presents each received byte on a valid/ack handshake, with framing-error and overrun reporting.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; integer >= 4; H = CLKS_PER_BIT/2 (integer division).

Ports:
clock  input  1  system clock; all logic on posedge.
reset_n  input  1  reset, asynchronous and active-low.
rx  input  1  serial line, idle high, asynchronous to clock.
data  output  8  last correctly framed byte; held until the next good frame.
valid  output  1  level; high while data is unacknowledged.
ack  input  1  consumer acknowledge; sampled only while valid = 1.
frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
overrun  output  1  one-cycle pulse when a good byte completes while valid = 1 and ack = 0.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, asserted asynchronously:
  - Outputs: data = 0x00; valid = 0; frame_error = 0; overrun = 0; busy = 0.
  - Internal: both synchroniser flops = 1; state = IDLE; counters and shift register = 0.
- Synchroniser: rx passes through 2 flops to give rx_s. All FSM decisions use rx_s only.
- State IDLE:
  - When rx_s = 0 -> START, clk_cnt <= 0.
- State START:
  - clk_cnt increments each cycle.
  - When clk_cnt = H-1: if rx_s = 0 -> DATA with clk_cnt <= 0, bit_cnt <= 0.
  - Otherwise the low was a glitch -> IDLE. No outputs change.
- State DATA:
  - clk_cnt increments each cycle.
  - When clk_cnt = CLKS_PER_BIT-1: shift rx_s into the MSB of shift_reg (shift right), clk_cnt <= 0, bit_cnt++.
  - On the 8th sample (bit_cnt = 7) -> STOP.
- State STOP:
  - When clk_cnt = CLKS_PER_BIT-1, sample rx_s.
  - If rx_s = 1: data <= shift_reg, valid <= 1 -> IDLE. IDLE is re-armed from mid-stop-bit, so back-to-back frames are accepted.
  - If rx_s = 0: frame_error pulses for 1 cycle; data and valid are unchanged -> WAIT_HIGH.
- State WAIT_HIGH:
  - Stays until rx_s = 1 -> IDLE. A break condition (line held low) therefore yields exactly one frame_error.
- Handshake:
  - ack = 1 while valid = 1 clears valid on the next edge.
  - ack while valid = 0 is ignored.
- Simultaneous events:
  - Good byte completes in the same cycle as ack: the new byte loads, valid stays 1, no overrun.
  - Good byte completes while valid = 1 and ack = 0: data is overwritten, valid stays 1, overrun pulses for 1 cycle.
- Latency: valid rises exactly H + 9*CLKS_PER_BIT + 3 clock edges after the first edge that samples rx low into the first synchroniser flop.
- Widths:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits and never wraps past CLKS_PER_BIT-1.
  - bit_cnt is 3 bits.
- Reset mid-frame: the partial byte is discarded. After reset release the receiver waits for a fresh falling edge; a line that is already low starts a frame, and START's mid-bit check decides whether it is accepted.
- Default FSM branch -> IDLE.

Decomposition:
- Package uart_pkg:
  - typedef enum uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - localparam UART_DATA_BITS = 8.
  - localparam UART_IDLE_LEVEL = 1'b1, shared with the transmitter.
- Sub-module sync_2ff: parameterised-width 2-flop synchroniser with async active-low reset to a parameter value (1 here). It is reusable for other asynchronous inputs.

Test Plan:
(All scenarios use CLKS_PER_BIT = 16, so H = 8.)
1. Drive 0xA5 (8N1, LSB first, 16 cycles/bit) -> valid rises 155 edges after the start bit is first sampled; data = 0xA5; frame_error = 0; overrun = 0.
2. Drive rx low for 4 cycles then high -> busy pulses; state returns to IDLE; valid, data and frame_error unchanged.
3. Drive 0x3C with the stop bit low, line held low 40 more bits -> exactly one frame_error pulse; data keeps its previous value; valid = 0; busy stays high until rx returns high.
4. Drive 0x11 then 0x22 back-to-back with ack = 0 -> one overrun pulse at the second completion; data = 0x22; valid = 1.
5. Drive 0x55 with ack asserted in the exact cycle 0x66 completes (valid already 1) -> data = 0x66; valid = 1; no overrun. Next-cycle ack -> valid = 0.
6. Assert reset_n = 0 mid-bit 4 of 0xF0 -> all outputs 0 immediately (async). After release, drive 0x81 -> data = 0x81, valid = 1, no frame_error.
